multicycle_ctrl: RTL and testbench

Control FSM for the multi-cycle LEGv8 datapath. It shares one ALU and one unified instruction/data memory across the steps of each instruction.
- Supports ldur, stur, cbz, add, sub, and, orr.
- Sequences fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake.
- Counts retired instructions.
- Sits between the IR opcode field and the datapath mux/enable controls, replacing the single-cycle decoder.

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/opclass_dec.sv | 17 +
 rtl/multicycle_ctrl.sv | 76 +++++++
 tb/tb_multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state, opcode and control-word definitions for the multicycle LEGv8 controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, LDWB, MEMWR, EXEC, RWB, BRANCH
  } state_t;

  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [7:0]  OP_CBZ8 = 8'b1011_0100;
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       fetch;
  } ctrl_t;

  // Moore control word for each state; fetch marks where IRWrite/PCWrite follow mem_ready.
  function automatic ctrl_t ctrl_of(state_t s);
    ctrl_t c = '0;
    case (s)
      FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; c.alu_op = ALUOP_ADD; c.fetch = 1'b1; end
      DECODE: begin c.alu_src_b = SRCB_IMM4; c.alu_op = ALUOP_ADD; end
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_ADD; end
      MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      LDWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      EXEC:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG; c.alu_op = ALUOP_FUNCT; end
      RWB:    c.reg_write = 1'b1;
      BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG; c.alu_op = ALUOP_PASSB;
        c.pc_write_cond = 1'b1; c.pc_src = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - opcode/handshake inputs and datapath controls of the multicycle controller
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [10:0]      Op;
  logic             mem_ready;
  logic             Reg2Loc;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             MemRead;
  logic             MemWrite;
  logic             IorD;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             PCSrc;
  logic             illegal;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Op, mem_ready,
    output Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, MemRead, MemWrite, IorD, IRWrite,
           MemtoReg, RegWrite, PCWrite, PCWriteCond, PCSrc, illegal, instr_done, instr_count
  );

  modport slave (
    output Op, mem_ready,
    input  Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, MemRead, MemWrite, IorD, IRWrite,
           MemtoReg, RegWrite, PCWrite, PCWriteCond, PCSrc, illegal, instr_done, instr_count
  );
endinterface

// File: rtl/opclass_dec.sv
// rtl/opclass_dec.sv - classifies an 11-bit LEGv8 opcode into the supported instruction groups
module opclass_dec
  import ctrl_pkg::*;
(
  input  logic [10:0] op,
  output logic        is_ldur,
  output logic        is_stur,
  output logic        is_cbz,
  output logic        is_rtype,
  output logic        is_illegal
);
  assign is_ldur    = (op == OP_LDUR);
  assign is_stur    = (op == OP_STUR);
  assign is_cbz     = (op[10:3] == OP_CBZ8);
  assign is_rtype   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
  assign is_illegal = !(is_ldur || is_stur || is_cbz || is_rtype);
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle LEGv8 control FSM with memory stall handshake and retire counter
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);
  state_t           state, nxt;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] count;
  logic             is_ldur, is_stur, is_cbz, is_rtype, is_illegal;
  logic             retire;

  opclass_dec u_dec (
    .op        (bus.Op),
    .is_ldur   (is_ldur),
    .is_stur   (is_stur),
    .is_cbz    (is_cbz),
    .is_rtype  (is_rtype),
    .is_illegal(is_illegal)
  );

  always_comb begin
    nxt = state;
    case (state)
      FETCH:  if (bus.mem_ready) nxt = DECODE;
      DECODE: begin
        if (is_ldur || is_stur) nxt = MEMADR;
        else if (is_rtype)      nxt = EXEC;
        else if (is_cbz)        nxt = BRANCH;
        else                    nxt = FETCH;
      end
      MEMADR: nxt = is_ldur ? MEMRD : MEMWR;
      MEMRD:  if (bus.mem_ready) nxt = LDWB;
      MEMWR:  if (bus.mem_ready) nxt = FETCH;
      EXEC:   nxt = RWB;
      LDWB, RWB, BRANCH: nxt = FETCH;
      default: nxt = FETCH;
    endcase
  end

  assign retire = !reset && ((state inside {LDWB, RWB, BRANCH}) || (state == MEMWR && bus.mem_ready));

  // The control word is registered alongside the state so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      ctrl_q <= ctrl_of(FETCH);
      count  <= '0;
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_of(nxt);
      if (retire) count <= count + CNT_W'(1);
    end
  end

  assign bus.Reg2Loc     = !reset && (is_stur || is_cbz);
  assign bus.ALUSrcA     = !reset && ctrl_q.alu_src_a;
  assign bus.ALUSrcB     = reset ? 2'b00 : ctrl_q.alu_src_b;
  assign bus.ALUOp       = reset ? 2'b00 : ctrl_q.alu_op;
  assign bus.MemRead     = !reset && ctrl_q.mem_read;
  assign bus.MemWrite    = !reset && ctrl_q.mem_write;
  assign bus.IorD        = !reset && ctrl_q.iord;
  assign bus.IRWrite     = !reset && ctrl_q.fetch && bus.mem_ready;
  assign bus.PCWrite     = !reset && ctrl_q.fetch && bus.mem_ready;
  assign bus.MemtoReg    = !reset && ctrl_q.mem_to_reg;
  assign bus.RegWrite    = !reset && ctrl_q.reg_write;
  assign bus.PCWriteCond = !reset && ctrl_q.pc_write_cond;
  assign bus.PCSrc       = !reset && ctrl_q.pc_src;
  assign bus.illegal     = !reset && (state == DECODE) && is_illegal;
  assign bus.instr_done  = retire;
  assign bus.instr_count = reset ? '0 : count;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl with an instruction-level reference model
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  localparam int CW = 4;

  typedef enum {C_LDUR, C_STUR, C_CBZ, C_RTYPE, C_ILL} cls_e;
  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_LDWB, P_MEMWR, P_EXEC, P_RWB, P_BRANCH} phase_e;
  typedef struct packed {
    logic       reg2loc, srca;
    logic [1:0] srcb, aluop;
    logic       memread, memwrite, iord, irwrite, memtoreg, regwrite, pcwrite, pcwc, pcsrc, illegal, done;
  } outs_t;
  typedef struct {
    logic [10:0] op;
    int          lat;
    int          inc;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  int    checks = 0;
  int    failures = 0;
  int    model_cnt = 0;
  outs_t act;
  vec_t  tbl[13];

  multicycle_ctrl_if #(.CNT_W(CW)) bus ();
  multicycle_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  assign act = {bus.Reg2Loc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.MemRead, bus.MemWrite, bus.IorD,
                bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.PCWrite, bus.PCWriteCond, bus.PCSrc,
                bus.illegal, bus.instr_done};

  function automatic cls_e classify(logic [10:0] op);
    if (op == 11'b111_1100_0010) return C_LDUR;
    if (op == 11'b111_1100_0000) return C_STUR;
    if (op[10:3] == 8'b1011_0100) return C_CBZ;
    if (op == 11'b100_0101_1000 || op == 11'b110_0101_1000 ||
        op == 11'b100_0101_0000 || op == 11'b101_0101_0000) return C_RTYPE;
    return C_ILL;
  endfunction

  function automatic outs_t exp_out(phase_e p, cls_e c, logic rdy);
    outs_t o = '0;
    o.reg2loc = (c == C_STUR || c == C_CBZ);
    case (p)
      P_FETCH:  begin o.memread = 1; o.srcb = 2'b01; o.irwrite = rdy; o.pcwrite = rdy; end
      P_DECODE: begin o.srcb = 2'b11; o.illegal = (c == C_ILL); end
      P_MEMADR: begin o.srca = 1; o.srcb = 2'b10; end
      P_MEMRD:  begin o.memread = 1; o.iord = 1; end
      P_LDWB:   begin o.regwrite = 1; o.memtoreg = 1; o.done = 1; end
      P_MEMWR:  begin o.memwrite = 1; o.iord = 1; o.done = rdy; end
      P_EXEC:   begin o.srca = 1; o.aluop = 2'b10; end
      P_RWB:    begin o.regwrite = 1; o.done = 1; end
      P_BRANCH: begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 1; o.done = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Runs one instruction from FETCH; fstall/mstall hold mem_ready low in fetch/memory phases,
  // rnd draws mem_ready randomly instead. Non-request phases always see a random mem_ready.
  task automatic run_instr(input logic [10:0] op, input int fstall, input int mstall, input bit rnd,
                           output int cycles);
    cls_e   c = classify(op);
    phase_e ph[$];
    int     idx = 0;
    int     waited = 0;
    bit     wph;
    logic   rdy;
    outs_t  e;
    ph.push_back(P_FETCH);
    ph.push_back(P_DECODE);
    case (c)
      C_LDUR:  begin ph.push_back(P_MEMADR); ph.push_back(P_MEMRD); ph.push_back(P_LDWB); end
      C_STUR:  begin ph.push_back(P_MEMADR); ph.push_back(P_MEMWR); end
      C_RTYPE: begin ph.push_back(P_EXEC); ph.push_back(P_RWB); end
      C_CBZ:   ph.push_back(P_BRANCH);
      default: ;
    endcase
    bus.Op = op;
    cycles = 0;
    while (idx < ph.size() && cycles < 100) begin
      wph = (ph[idx] == P_FETCH || ph[idx] == P_MEMRD || ph[idx] == P_MEMWR);
      if (!wph)     rdy = 1'($urandom_range(0, 1));
      else if (rnd) rdy = ($urandom_range(0, 2) != 0);
      else          rdy = (waited >= ((ph[idx] == P_FETCH) ? fstall : mstall));
      bus.mem_ready = rdy;
      e = exp_out(ph[idx], c, rdy);
      @(negedge clk);
      check($sformatf("%s op=%b outs", ph[idx].name(), op), 32'(act), 32'(e));
      check($sformatf("%s op=%b instr_count", ph[idx].name(), op), 32'(bus.instr_count), 32'(model_cnt));
      if (e.done) model_cnt = (model_cnt + 1) % (1 << CW);
      @(posedge clk); #1;
      cycles++;
      if (!wph || rdy) begin idx++; waited = 0; end
      else waited++;
    end
    if (idx < ph.size()) begin
      checks++; failures++;
      $display("FAIL timeout op=%b: phase %0d of %0d", op, idx, ph.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int tcnt;
    tbl[0]  = '{11'b100_0101_1000, 4, 1};
    tbl[1]  = '{11'b110_0101_1000, 4, 1};
    tbl[2]  = '{11'b100_0101_0000, 4, 1};
    tbl[3]  = '{11'b101_0101_0000, 4, 1};
    tbl[4]  = '{11'b111_1100_0010, 5, 1};
    tbl[5]  = '{11'b111_1100_0000, 4, 1};
    tbl[6]  = '{11'b101_1010_0000, 3, 1};
    tbl[7]  = '{11'b101_1010_0111, 3, 1};
    tbl[8]  = '{11'b000_0000_0000, 2, 0};
    tbl[9]  = '{11'b111_1100_0001, 2, 0};
    tbl[10] = '{11'b100_0101_1001, 2, 0};
    tbl[11] = '{11'b111_1111_1111, 2, 0};
    tbl[12] = '{11'b101_1010_1000, 2, 0};

    // Reset with stur and mem_ready high: every output must still be 0.
    bus.Op = 11'b111_1100_0000;
    bus.mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset outs", 32'(act), 32'd0);
      check("reset instr_count", 32'(bus.instr_count), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(11'b100_0101_1000, 0, 0, 1'b0, cyc);
    check("add latency", cyc, 4);
    check("add instr_count", 32'(bus.instr_count), 32'd1);
    run_instr(11'b111_1100_0010, 0, 3, 1'b0, cyc);
    check("ldur stalled latency", cyc, 8);
    run_instr(11'b111_1100_0000, 0, 0, 1'b0, cyc);
    check("stur latency", cyc, 4);
    run_instr(11'b101_1010_0101, 0, 0, 1'b0, cyc);
    check("cbz latency", cyc, 3);
    run_instr(11'b000_0000_0000, 0, 0, 1'b0, cyc);
    check("illegal latency", cyc, 2);
    check("illegal instr_count", 32'(bus.instr_count), 32'd4);
    run_instr(11'b111_1100_0000, 2, 2, 1'b0, cyc);
    check("stur stalled latency", cyc, 8);

    tcnt = 5;
    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].op, 0, 0, 1'b0, cyc);
      tcnt = (tcnt + tbl[i].inc) % (1 << CW);
      check($sformatf("table op=%b latency", tbl[i].op), cyc, tbl[i].lat);
      check($sformatf("table op=%b instr_count", tbl[i].op), 32'(bus.instr_count), 32'(tcnt));
    end

    // Reset in the middle of a MEMWR stall: the store must not retire.
    bus.Op = 11'b111_1100_0000;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("memwr stall MemWrite", 32'(bus.MemWrite), 32'd1);
    check("memwr stall instr_done", 32'(bus.instr_done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid-stall reset outs", 32'(act), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("after reset outs", 32'(act), 32'd0);
    check("after reset instr_count", 32'(bus.instr_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    check("post reset fetch outs", 32'(act), 32'(exp_out(P_FETCH, C_STUR, 1'b0)));
    @(posedge clk); #1;

    while (model_cnt != (1 << CW) - 1) run_instr(11'b100_0101_1000, 0, 0, 1'b0, cyc);
    run_instr(11'b101_1010_0011, 0, 0, 1'b0, cyc);
    check("counter wrap", 32'(bus.instr_count), 32'd0);

    for (int i = 0; i < 80; i++) begin
      logic [10:0] op;
      case ($urandom_range(0, 5))
        0: op = 11'b111_1100_0010;
        1: op = 11'b111_1100_0000;
        2: op = {8'b1011_0100, 3'($urandom)};
        3: case ($urandom_range(0, 3))
             0: op = 11'b100_0101_1000;
             1: op = 11'b110_0101_1000;
             2: op = 11'b100_0101_0000;
             default: op = 11'b101_0101_0000;
           endcase
        4: op = 11'($urandom);
        default: op = 11'b100_0101_1000;
      endcase
      run_instr(op, 0, 0, 1'b1, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
